// File: rtl/riscv_tb_pkg.sv
// Shared definitions for the RISC-V test monitor: FSM state encoding and
// default sizing of the milestone table, datapath and watchdog.
package riscv_tb_pkg;

  localparam int DEF_NUM_TEST = 21;
  localparam int DEF_DWIDTH   = 32;
  localparam int DEF_CWIDTH   = 32;
  localparam int DEF_TIMEOUT  = 100000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_DONE_PASS = 3'd2,
    ST_DONE_FAIL = 3'd3,
    ST_TMO       = 3'd4
  } state_e;

endpackage

// File: rtl/test_table.sv
// Milestone table: NUM_TEST entries of {instruction count, expected answer}.
// One synchronous write port, one combinational read port; contents are never reset.
module test_table #(
  parameter int NUM_TEST = 21,
  parameter int DWIDTH   = 32,
  parameter int IW       = 5
) (
  input  logic              CLK,
  input  logic              we_i,
  input  logic [IW-1:0]     widx_i,
  input  logic [DWIDTH-1:0] wnum_i,
  input  logic [DWIDTH-1:0] wans_i,
  input  logic [IW-1:0]     ridx_i,
  output logic [DWIDTH-1:0] rnum_o,
  output logic [DWIDTH-1:0] rans_o
);

  logic [2*DWIDTH-1:0] mem_q [NUM_TEST];
  logic [2*DWIDTH-1:0] rd_d;

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_TEST; i++) begin
      if (we_i && (widx_i == IW'(i))) mem_q[i] <= {wnum_i, wans_i};
    end
  end

  // An index past the last entry (ptr == count == NUM_TEST) reads as zero.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_TEST; i++) begin
      if (ridx_i == IW'(i)) rd_d = mem_q[i];
    end
  end

  assign rnum_o = rd_d[2*DWIDTH-1:DWIDTH];
  assign rans_o = rd_d[DWIDTH-1:0];

endmodule

// File: rtl/riscv_test_monitor.sv
// Watches a core's retired-instruction count and result port, checking each
// table milestone once, and reports a sticky pass/fail/timeout verdict.
module riscv_test_monitor
  import riscv_tb_pkg::*;
#(
  parameter int NUM_TEST     = DEF_NUM_TEST,
  parameter int DWIDTH       = DEF_DWIDTH,
  parameter int CWIDTH       = DEF_CWIDTH,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int STOP_ON_FAIL = 1,
  localparam int IW          = $clog2(NUM_TEST + 1)
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              LOAD_EN,
  input  logic [IW-1:0]     LOAD_IDX,
  input  logic [DWIDTH-1:0] LOAD_NUM,
  input  logic [DWIDTH-1:0] LOAD_ANS,
  input  logic [IW-1:0]     TEST_CNT,
  input  logic              START,
  input  logic [DWIDTH-1:0] NUM_INST,
  input  logic [DWIDTH-1:0] OUTPUT_PORT,
  input  logic              HALT,
  output logic [2:0]        STATE,
  output logic              PASS,
  output logic              FAIL,
  output logic              TIMED_OUT,
  output logic [IW-1:0]     PASS_CNT,
  output logic [IW-1:0]     ERR_CNT,
  output logic [IW-1:0]     FAIL_IDX,
  output logic [DWIDTH-1:0] FAIL_VAL,
  output logic [CWIDTH-1:0] CYCLE
);

  localparam logic [CWIDTH-1:0] TMO_LAST = CWIDTH'(TIMEOUT - 1);
  localparam logic              STOP     = (STOP_ON_FAIL != 0);

  state_e              state_q;
  logic                pass_q, fail_q, tmo_q;
  logic [IW-1:0]       ptr_q, cnt_q, pass_cnt_q, err_cnt_q, fail_idx_q;
  logic [DWIDTH-1:0]   fail_val_q;
  logic [CWIDTH-1:0]   cycle_q;

  logic [DWIDTH-1:0]   tbl_num, tbl_ans;
  logic                tbl_we;
  logic                due, miss, hit, bad, adv;
  logic [IW-1:0]       ptr_d, pass_cnt_d, err_cnt_d, cnt_d;

  assign tbl_we = (state_q == ST_IDLE) && LOAD_EN && (LOAD_IDX < IW'(NUM_TEST));
  assign cnt_d  = (TEST_CNT > IW'(NUM_TEST)) ? IW'(NUM_TEST) : TEST_CNT;

  test_table #(
    .NUM_TEST (NUM_TEST),
    .DWIDTH   (DWIDTH),
    .IW       (IW)
  ) u_table (
    .CLK    (CLK),
    .we_i   (tbl_we),
    .widx_i (LOAD_IDX),
    .wnum_i (LOAD_NUM),
    .wans_i (LOAD_ANS),
    .ridx_i (ptr_q),
    .rnum_o (tbl_num),
    .rans_o (tbl_ans)
  );

  // A count past the milestone means it was skipped and counts as a mismatch.
  always_comb begin
    due  = 1'b0;
    miss = 1'b0;
    if (ptr_q < cnt_q) begin
      due  = (NUM_INST == tbl_num);
      miss = (NUM_INST > tbl_num);
    end
    hit        = due && (OUTPUT_PORT == tbl_ans);
    bad        = (due || miss) && !hit;
    adv        = (due || miss) && !(bad && STOP);
    pass_cnt_d = pass_cnt_q + IW'(hit);
    err_cnt_d  = err_cnt_q + IW'(bad);
    ptr_d      = ptr_q + IW'(adv);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      tmo_q      <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      pass_cnt_q <= '0;
      err_cnt_q  <= '0;
      fail_idx_q <= '0;
      fail_val_q <= '0;
      cycle_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_q    <= ST_RUN;
            cnt_q      <= cnt_d;
            ptr_q      <= '0;
            pass_cnt_q <= '0;
            err_cnt_q  <= '0;
            fail_idx_q <= '0;
            fail_val_q <= '0;
            cycle_q    <= '0;
          end
        end
        ST_RUN: begin
          ptr_q      <= ptr_d;
          pass_cnt_q <= pass_cnt_d;
          err_cnt_q  <= err_cnt_d;
          if (bad && (err_cnt_q == '0)) begin
            fail_idx_q <= ptr_q;
            fail_val_q <= OUTPUT_PORT;
          end
          if (HALT) begin
            if ((err_cnt_d == '0) && (ptr_d == cnt_q)) begin
              state_q <= ST_DONE_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE_FAIL;
              fail_q  <= 1'b1;
              if (err_cnt_d == '0) begin
                fail_idx_q <= ptr_d;
                fail_val_q <= OUTPUT_PORT;
              end
            end
          end else if (bad && STOP) begin
            state_q <= ST_DONE_FAIL;
            fail_q  <= 1'b1;
          end else if (cycle_q == TMO_LAST) begin
            state_q <= ST_TMO;
            fail_q  <= 1'b1;
            tmo_q   <= 1'b1;
          end else if (cycle_q != '1) begin
            cycle_q <= cycle_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign STATE     = state_q;
  assign PASS      = pass_q;
  assign FAIL      = fail_q;
  assign TIMED_OUT = tmo_q;
  assign PASS_CNT  = pass_cnt_q;
  assign ERR_CNT   = err_cnt_q;
  assign FAIL_IDX  = fail_idx_q;
  assign FAIL_VAL  = fail_val_q;
  assign CYCLE     = cycle_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: two instances (stop-on-fail and continue) share
// stimulus; expected verdict fields are queued per scenario and drained at the verdict.
module tb_riscv_test_monitor;

  localparam int NT = 21;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam int IW = $clog2(NT + 1);

  localparam int F_STATE = 0, F_PASS = 1, F_FAIL = 2, F_TMO = 3, F_PCNT = 4,
                 F_ECNT = 5, F_FIDX = 6, F_FVAL = 7, F_CYC = 8;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          LOAD_EN = 1'b0;
  logic [IW-1:0] LOAD_IDX = '0;
  logic [DW-1:0] LOAD_NUM = '0;
  logic [DW-1:0] LOAD_ANS = '0;
  logic [IW-1:0] TEST_CNT = '0;
  logic          START = 1'b0;
  logic [DW-1:0] NUM_INST = '0;
  logic [DW-1:0] OUTPUT_PORT = '0;
  logic          HALT = 1'b0;

  logic [2:0]    st   [2];
  logic          pas  [2];
  logic          fl   [2];
  logic          tmo  [2];
  logic [IW-1:0] pcnt [2];
  logic [IW-1:0] ecnt [2];
  logic [IW-1:0] fidx [2];
  logic [DW-1:0] fval [2];
  logic [CW-1:0] cyc  [2];

  always #5 CLK = ~CLK;

  riscv_test_monitor #(.NUM_TEST(NT), .DWIDTH(DW), .CWIDTH(CW), .TIMEOUT(50), .STOP_ON_FAIL(1)) u_stop (
    .CLK(CLK), .RSTn(RSTn), .LOAD_EN(LOAD_EN), .LOAD_IDX(LOAD_IDX), .LOAD_NUM(LOAD_NUM),
    .LOAD_ANS(LOAD_ANS), .TEST_CNT(TEST_CNT), .START(START), .NUM_INST(NUM_INST),
    .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT), .STATE(st[0]), .PASS(pas[0]), .FAIL(fl[0]),
    .TIMED_OUT(tmo[0]), .PASS_CNT(pcnt[0]), .ERR_CNT(ecnt[0]), .FAIL_IDX(fidx[0]),
    .FAIL_VAL(fval[0]), .CYCLE(cyc[0]));

  riscv_test_monitor #(.NUM_TEST(NT), .DWIDTH(DW), .CWIDTH(CW), .TIMEOUT(50), .STOP_ON_FAIL(0)) u_cont (
    .CLK(CLK), .RSTn(RSTn), .LOAD_EN(LOAD_EN), .LOAD_IDX(LOAD_IDX), .LOAD_NUM(LOAD_NUM),
    .LOAD_ANS(LOAD_ANS), .TEST_CNT(TEST_CNT), .START(START), .NUM_INST(NUM_INST),
    .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT), .STATE(st[1]), .PASS(pas[1]), .FAIL(fl[1]),
    .TIMED_OUT(tmo[1]), .PASS_CNT(pcnt[1]), .ERR_CNT(ecnt[1]), .FAIL_IDX(fidx[1]),
    .FAIL_VAL(fval[1]), .CYCLE(cyc[1]));

  typedef struct {
    int          inst;
    int          fld;
    logic [63:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(input int inst, input int fld);
    case (fld)
      F_STATE: return 64'(st[inst]);
      F_PASS:  return 64'(pas[inst]);
      F_FAIL:  return 64'(fl[inst]);
      F_TMO:   return 64'(tmo[inst]);
      F_PCNT:  return 64'(pcnt[inst]);
      F_ECNT:  return 64'(ecnt[inst]);
      F_FIDX:  return 64'(fidx[inst]);
      F_FVAL:  return 64'(fval[inst]);
      default: return 64'(cyc[inst]);
    endcase
  endfunction

  task automatic push(input int inst, input int fld, input longint val, input string tag);
    exp_t e;
    e.inst = inst;
    e.fld  = fld;
    e.val  = 64'(val);
    e.tag  = $sformatf("%s/%s", tag, inst == 0 ? "stop" : "cont");
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, obs(e.inst, e.fld), e.val);
    end
  endtask

  // Bounded wait for both instances to reach a terminal state.
  task automatic wait_done(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      done = (st[0] >= 3'd2) && (st[1] >= 3'd2);
    end
    check_val({tag, "_verdict_reached"}, 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0; START = 1'b0; HALT = 1'b0; NUM_INST = '0; OUTPUT_PORT = '0;
    @(negedge CLK);
    RSTn = 1'b1;
  endtask

  task automatic load(input int idx, input int num, input int ans);
    @(negedge CLK);
    LOAD_EN = 1'b1; LOAD_IDX = IW'(idx); LOAD_NUM = DW'(num); LOAD_ANS = DW'(ans);
    @(negedge CLK);
    LOAD_EN = 1'b0;
  endtask

  task automatic start(input int cnt);
    @(negedge CLK);
    START = 1'b1; TEST_CNT = IW'(cnt); NUM_INST = '0; HALT = 1'b0;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic step(input int num, input int out);
    @(negedge CLK);
    NUM_INST = DW'(num); OUTPUT_PORT = DW'(out);
  endtask

  task automatic halt_pulse();
    @(negedge CLK);
    HALT = 1'b1;
    @(negedge CLK);
    HALT = 1'b0;
  endtask

  task automatic good_run();
    start(3);
    step(1, 5); step(2, 0); step(3, 1);
    halt_pulse();
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 2; i++) begin
      push(i, F_STATE, 0, "rst_state"); push(i, F_PASS, 0, "rst_pass");
      push(i, F_FAIL, 0, "rst_fail");   push(i, F_TMO, 0, "rst_tmo");
      push(i, F_PCNT, 0, "rst_pcnt");   push(i, F_ECNT, 0, "rst_ecnt");
      push(i, F_FIDX, 0, "rst_fidx");   push(i, F_FVAL, 0, "rst_fval");
      push(i, F_CYC, 0, "rst_cycle");
    end
    drain();

    load(0, 1, 5); load(1, 2, 0); load(2, 3, 1);
    load(25, 1, 99);

    // All milestones correct.
    for (int i = 0; i < 2; i++) begin
      push(i, F_STATE, 2, "pass_state"); push(i, F_PASS, 1, "pass_flag");
      push(i, F_FAIL, 0, "pass_fail");   push(i, F_PCNT, 3, "pass_pcnt");
      push(i, F_ECNT, 0, "pass_ecnt");
    end
    good_run();
    wait_done("pass");
    drain();

    // Entry 1 returns 7; later START must not leave the terminal state.
    do_reset();
    push(0, F_STATE, 3, "e1_state"); push(0, F_FIDX, 1, "e1_fidx");
    push(0, F_FVAL, 7, "e1_fval");   push(0, F_PCNT, 1, "e1_pcnt");
    push(0, F_ECNT, 1, "e1_ecnt");   push(0, F_FAIL, 1, "e1_fail");
    push(1, F_STATE, 3, "e1_state"); push(1, F_FIDX, 1, "e1_fidx");
    push(1, F_FVAL, 7, "e1_fval");   push(1, F_PCNT, 2, "e1_pcnt");
    push(1, F_ECNT, 1, "e1_ecnt");
    start(3);
    step(1, 5); step(2, 7); step(3, 1);
    halt_pulse();
    wait_done("e1");
    start(3);
    drain();

    // Entries 0 and 2 wrong.
    do_reset();
    push(0, F_STATE, 3, "e02_state"); push(0, F_FIDX, 0, "e02_fidx");
    push(0, F_FVAL, 9, "e02_fval");   push(0, F_ECNT, 1, "e02_ecnt");
    push(0, F_PCNT, 0, "e02_pcnt");
    push(1, F_STATE, 3, "e02_state"); push(1, F_FIDX, 0, "e02_fidx");
    push(1, F_FVAL, 9, "e02_fval");   push(1, F_ECNT, 2, "e02_ecnt");
    push(1, F_PCNT, 1, "e02_pcnt");
    start(3);
    step(1, 9); step(2, 0); step(3, 4);
    halt_pulse();
    wait_done("e02");
    drain();

    // NUM_INST jumps 1 -> 3, skipping entry 1.
    do_reset();
    push(0, F_STATE, 3, "skip_state"); push(0, F_FIDX, 1, "skip_fidx");
    push(0, F_FVAL, 1, "skip_fval");   push(0, F_ECNT, 1, "skip_ecnt");
    push(1, F_STATE, 3, "skip_state"); push(1, F_FIDX, 1, "skip_fidx");
    push(1, F_PCNT, 2, "skip_pcnt");   push(1, F_ECNT, 1, "skip_ecnt");
    start(3);
    step(1, 5); step(3, 1); step(3, 1);
    halt_pulse();
    wait_done("skip");
    drain();

    // Watchdog with no HALT.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      push(i, F_STATE, 4, "tmo_state"); push(i, F_CYC, 49, "tmo_cycle");
      push(i, F_TMO, 1, "tmo_flag");    push(i, F_FAIL, 1, "tmo_fail");
      push(i, F_PASS, 0, "tmo_pass");
    end
    start(0);
    wait_done("tmo");
    drain();

    // HALT on the last cycle before expiry wins over the watchdog.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      push(i, F_STATE, 2, "h49_state"); push(i, F_TMO, 0, "h49_tmo");
      push(i, F_PASS, 1, "h49_pass");
    end
    start(0);
    repeat (49) @(posedge CLK);
    @(negedge CLK);
    HALT = 1'b1;
    @(negedge CLK);
    HALT = 1'b0;
    wait_done("h49");
    drain();

    // Reset mid-run (with a stray load attempt), then a clean rerun.
    do_reset();
    start(3);
    step(1, 5);
    load(0, 100, 100);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      push(i, F_STATE, 0, "mid_rst_state"); push(i, F_PCNT, 0, "mid_rst_pcnt");
    end
    drain();
    for (int i = 0; i < 2; i++) begin
      push(i, F_STATE, 2, "rerun_state"); push(i, F_PCNT, 3, "rerun_pcnt");
      push(i, F_ECNT, 0, "rerun_ecnt");
    end
    good_run();
    wait_done("rerun");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_test_monitor.md
RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

Interface
REQ-001 Parameter NUM_TEST, default 21: table depth, maximum number of milestone checks.
REQ-002 Parameter DWIDTH, default 32: width of NUM_INST, OUTPUT_PORT and answers.
REQ-003 Parameter CWIDTH, default 32: cycle-counter width.
REQ-004 Parameter TIMEOUT, default 100000: cycles in RUN before watchdog expiry.
REQ-005 Parameter STOP_ON_FAIL, default 1: 1 = first mismatch is terminal; 0 = log the mismatch and continue.
REQ-006 Derived IW = clog2(NUM_TEST+1).
REQ-007 Reset RSTn, synchronous, active-low; clock CLK.
REQ-008 Port list (name, direction, width, meaning):
  CLK  in  1  clock
  RSTn  in  1  synchronous active-low reset
  LOAD_EN  in  1  table write strobe
  LOAD_IDX  in  IW  table entry index
  LOAD_NUM  in  DWIDTH  milestone instruction count
  LOAD_ANS  in  DWIDTH  expected OUTPUT_PORT value
  TEST_CNT  in  IW  active entries, sampled on START
  START  in  1  begin monitoring
  NUM_INST  in  DWIDTH  retired-instruction count from core
  OUTPUT_PORT  in  DWIDTH  core result port
  HALT  in  1  core halt
  STATE  out  3  FSM state
  PASS  out  1  verdict pass
  FAIL  out  1  verdict fail (mismatch, missed milestone or timeout)
  TIMED_OUT  out  1  watchdog expired
  PASS_CNT  out  IW  checks passed
  ERR_CNT  out  IW  checks failed
  FAIL_IDX  out  IW  first failing entry
  FAIL_VAL  out  DWIDTH  OUTPUT_PORT value at first failure
  CYCLE  out  CWIDTH  cycles spent in RUN

Function
REQ-009 States: IDLE=0, RUN=1, DONE_PASS=2, DONE_FAIL=3, TMO=4.
REQ-010 IDLE: a LOAD_EN with LOAD_IDX<NUM_TEST writes the entry on the next edge; LOAD_EN is ignored in other states or when LOAD_IDX>=NUM_TEST.
REQ-011 IDLE, START=1: latch TEST_CNT (clamped to NUM_TEST), clear ptr/counters/CYCLE, go to RUN. If the latched count is 0, HALT alone decides the verdict.
REQ-012 RUN: CYCLE increments every cycle and saturates at all-ones.
REQ-013 RUN, ptr<count, NUM_INST==num[ptr]: compare OUTPUT_PORT with ans[ptr] in the same cycle, then ptr++. Each entry is checked exactly once, even when NUM_INST holds for several cycles.
REQ-014 Match: PASS_CNT++.
REQ-015 Mismatch: ERR_CNT++. On the first error, record FAIL_IDX=ptr and FAIL_VAL=OUTPUT_PORT. If STOP_ON_FAIL=1, go to DONE_FAIL.
REQ-016 RUN, NUM_INST>num[ptr] (unsigned compare): the milestone was skipped. Treat it as a mismatch with FAIL_VAL=OUTPUT_PORT.
REQ-017 RUN, HALT=1: evaluate any check due in the same cycle first. Then go to DONE_PASS if ERR_CNT==0 (after the update) and ptr==count; otherwise go to DONE_FAIL. An unchecked entry records FAIL_IDX=ptr if no earlier failure exists.
REQ-018 RUN, CYCLE==TIMEOUT-1 without HALT: go to TMO. HALT in the same cycle takes priority over the timeout.
REQ-019 Terminal states (DONE_PASS, DONE_FAIL, TMO) are sticky until reset. START is ignored in them.
REQ-020 Status outputs:
  PASS = (STATE==DONE_PASS)
  FAIL = (STATE==DONE_FAIL or TMO)
  TIMED_OUT = (STATE==TMO)
  All outputs are registered.
REQ-021 Counters never wrap: at most NUM_TEST checks occur per run.

Reset
REQ-022 On RSTn=0 at a clock edge: STATE=IDLE; PASS, FAIL, TIMED_OUT=0; PASS_CNT, ERR_CNT, FAIL_IDX, ptr=0; FAIL_VAL=0; CYCLE=0.
REQ-023 Table contents are not reset and survive reset, so a reloaded core can be rerun without reloading the table.
REQ-024 A reset mid-RUN abandons the run with no verdict.

Structure
REQ-025 Shared package riscv_tb_pkg holds the state encoding and the default values of NUM_TEST, DWIDTH, CWIDTH and TIMEOUT.
REQ-026 Sub-module test_table holds the table:
  NUM_TEST x (2*DWIDTH) register array
  one synchronous write port
  one combinational read port indexed by ptr
REQ-027 The FSM, comparators and counters reside in riscv_test_monitor.

Verification
REQ-028 Table (1,5),(2,0),(3,1), TEST_CNT=3, NUM_INST steps 1..3 with correct answers, HALT after step 3 -> DONE_PASS, PASS_CNT=3, ERR_CNT=0.
REQ-029 STOP_ON_FAIL=1, entry1 sees OUTPUT_PORT=7 -> DONE_FAIL, FAIL_IDX=1, FAIL_VAL=7, ptr stops at 1.
REQ-030 STOP_ON_FAIL=0, entries 0 and 2 mismatch, HALT at end -> DONE_FAIL, ERR_CNT=2, PASS_CNT=1, FAIL_IDX=0.
REQ-031 NUM_INST jumps from 1 to 3 -> entry1 flagged as missed, FAIL_IDX=1.
REQ-032 TIMEOUT=50, no HALT -> TMO, CYCLE=49, TIMED_OUT=1. HALT exactly at CYCLE=49 -> verdict state, not TMO.
REQ-033 Reset asserted mid-RUN, then START -> fresh run; the table is unchanged and the test passes.
